// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV64 load/store unit controller: request capture, latency wait, single-cycle memory access, response
//
// Accepts one load/store request at a time, validates it, optionally waits LAT
// cycles, performs one aligned 8-byte memory access, and returns an aligned,
// extended load result (or an error flag) until downstream takes it.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   in_valid/in_ready          request handshake (in_ready high only in IDLE)
//   in_addr, in_wdata          byte address, right-aligned store data
//   in_funct3                  RV64 width/sign code
//   in_is_load, in_is_store    operation kind
//   out_valid/out_ready        response handshake
//   out_rdata, out_err         load result (0 otherwise), rejection flag
//   mem_raddr, mem_waddr       8-byte-aligned access address
//   mem_wdata, mem_wmask       lane-shifted store data and byte enables
//   mem_ren, mem_wen           one-cycle access strobes
//   mem_rdata                  read data, valid in the mem_ren cycle

module lsu_ctrl #(
  parameter int LAT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_load,
  input  logic        in_is_store,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata
);

  localparam logic [7:0] LAT8 = LAT[7:0];

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        load_q;
  logic        store_q;

  logic        in_misaligned;
  logic        in_err;
  logic        in_mem;
  logic [63:0] rd_shifted;
  logic [63:0] load_res;

  // Byte-lane enables for an access of the given width at the given offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] m;
    case (f3[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Request validation is done on the live inputs so the accept cycle can
  // already route errors and no-ops straight to RESP.
  always_comb begin
    in_misaligned = 1'b0;
    case (in_funct3[1:0])
      2'd1:    in_misaligned = in_addr[0];
      2'd2:    in_misaligned = (in_addr[1:0] != 2'd0);
      2'd3:    in_misaligned = (in_addr[2:0] != 3'd0);
      default: in_misaligned = 1'b0;
    endcase
    in_err = (in_is_load & in_is_store)
           | (in_is_load & (in_funct3 == 3'b111))
           | (in_is_store & in_funct3[2])
           | ((in_is_load | in_is_store) & in_misaligned);
    in_mem = (in_is_load | in_is_store) & ~in_err;
  end

  // Load result: move the addressed bytes down to bit 0, then truncate/extend.
  always_comb begin
    rd_shifted = mem_rdata >> {addr_q[2:0], 3'b000};
    case (funct3_q)
      3'b000:  load_res = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      3'b001:  load_res = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_res = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'b011:  load_res = rd_shifted;
      3'b100:  load_res = {56'd0, rd_shifted[7:0]};
      3'b101:  load_res = {48'd0, rd_shifted[15:0]};
      3'b110:  load_res = {32'd0, rd_shifted[31:0]};
      default: load_res = 64'd0;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign mem_raddr = {addr_q[63:3], 3'b000};
  assign mem_waddr = {addr_q[63:3], 3'b000};
  assign mem_wdata = wdata_q << {addr_q[2:0], 3'b000};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      funct3_q  <= 3'd0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= 64'd0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_wmask <= 8'd0;
    end else begin
      // Strobes and lane mask live for exactly the ACCESS cycle.
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_wmask <= 8'd0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            funct3_q <= in_funct3;
            load_q   <= in_is_load;
            store_q  <= in_is_store;
            if (in_mem) begin
              if (LAT8 != 8'd0) begin
                state <= WAIT;
                cnt   <= LAT8;
              end else begin
                state     <= ACCESS;
                mem_ren   <= in_is_load;
                mem_wen   <= in_is_store;
                mem_wmask <= lane_mask(in_funct3, in_addr[2:0]);
              end
            end else begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= in_err;
              out_rdata <= 64'd0;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd1) begin
            state     <= ACCESS;
            cnt       <= 8'd0;
            mem_ren   <= load_q;
            mem_wen   <= store_q;
            mem_wmask <= lane_mask(funct3_q, addr_q[2:0]);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACCESS: begin
          state     <= RESP;
          out_valid <= 1'b1;
          out_err   <= 1'b0;
          out_rdata <= load_q ? load_res : 64'd0;
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= 64'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl (LAT=0 vector table, LAT=3 corner sequences)

module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // LAT=0 instance
  logic        a_reset, a_in_valid, a_in_ready, a_in_is_load, a_in_is_store;
  logic        a_out_valid, a_out_ready, a_out_err, a_mem_ren, a_mem_wen;
  logic [2:0]  a_in_funct3;
  logic [7:0]  a_mem_wmask;
  logic [63:0] a_in_addr, a_in_wdata, a_out_rdata, a_mem_raddr, a_mem_waddr, a_mem_wdata, a_mem_rdata;

  // LAT=3 instance
  logic        b_reset, b_in_valid, b_in_ready, b_in_is_load, b_in_is_store;
  logic        b_out_valid, b_out_ready, b_out_err, b_mem_ren, b_mem_wen;
  logic [2:0]  b_in_funct3;
  logic [7:0]  b_mem_wmask;
  logic [63:0] b_in_addr, b_in_wdata, b_out_rdata, b_mem_raddr, b_mem_waddr, b_mem_wdata, b_mem_rdata;

  lsu_ctrl #(.LAT(0)) dut_a (
    .clock(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_addr(a_in_addr), .in_wdata(a_in_wdata), .in_funct3(a_in_funct3),
    .in_is_load(a_in_is_load), .in_is_store(a_in_is_store),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rdata(a_out_rdata), .out_err(a_out_err),
    .mem_raddr(a_mem_raddr), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_rdata(a_mem_rdata)
  );

  lsu_ctrl #(.LAT(3)) dut_b (
    .clock(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_addr(b_in_addr), .in_wdata(b_in_wdata), .in_funct3(b_in_funct3),
    .in_is_load(b_in_is_load), .in_is_store(b_in_is_store),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rdata(b_out_rdata), .out_err(b_out_err),
    .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_rdata(b_mem_rdata)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrd;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  strobe;     // 0 none, 1 read, 2 write
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  resp_t cur;
  vec_t  vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] mrd, input logic [63:0] erd, input logic err,
                               input logic [1:0] strobe, input logic [7:0] mask,
                               input logic [63:0] ewd);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.exp_rdata = erd; v.exp_err = err; v.strobe = strobe; v.exp_mask = mask; v.exp_wdata = ewd;
    return v;
  endfunction

  // Scoreboard: responses of the LAT=0 instance are popped as they are taken.
  always @(negedge clk) begin
    if (!a_reset && a_out_valid && a_out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        check("resp_rdata", a_out_rdata, cur.rdata);
        check("resp_err", {63'd0, a_out_err}, {63'd0, cur.err});
      end
    end
  end

  task automatic run_a(input vec_t v);
    int first_valid, strobe_cyc, ren_n, wen_n, waitc;
    logic zero_ok;
    logic [7:0]  mk;
    logic [63:0] wd, ra;
    waitc = 0; mk = 8'd0; wd = 64'd0; ra = 64'd0;
    @(negedge clk);
    while (!a_in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_req", {63'd0, a_in_ready}, 64'd1);
    a_in_addr = v.addr; a_in_wdata = v.wdata; a_in_funct3 = v.f3;
    a_in_is_load = v.ld; a_in_is_store = v.st; a_mem_rdata = v.mrd;
    a_in_valid = 1'b1;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    first_valid = 0; strobe_cyc = 0; ren_n = 0; wen_n = 0; zero_ok = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (a_mem_ren) begin ren_n++; strobe_cyc = c; ra = a_mem_raddr; end
      if (a_mem_wen) begin wen_n++; strobe_cyc = c; mk = a_mem_wmask; wd = a_mem_wdata; ra = a_mem_waddr; end
      if (!a_mem_ren && !a_mem_wen && a_mem_wmask != 8'd0) zero_ok = 1'b0;
      if (!a_out_valid && (a_out_rdata != 64'd0 || a_out_err)) zero_ok = 1'b0;
      if (a_out_valid && first_valid == 0) first_valid = c;
    end
    check("ren_count", 64'(ren_n), (v.strobe == 2'd1) ? 64'd1 : 64'd0);
    check("wen_count", 64'(wen_n), (v.strobe == 2'd2) ? 64'd1 : 64'd0);
    check("out_latency", 64'(first_valid), (v.strobe != 2'd0) ? 64'd2 : 64'd1);
    check("idle_outputs_zero", {63'd0, zero_ok}, 64'd1);
    if (v.strobe != 2'd0) begin
      check("strobe_cycle", 64'(strobe_cyc), 64'd1);
      check("mem_addr", ra, {v.addr[63:3], 3'b000});
    end
    if (v.strobe == 2'd2) begin
      check("mem_wmask", {56'd0, mk}, {56'd0, v.exp_mask});
      check("mem_wdata", wd, v.exp_wdata);
    end
  endtask

  task automatic drive_b(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] mrd);
    b_in_addr = addr; b_in_wdata = 64'd0; b_in_funct3 = f3;
    b_in_is_load = ld; b_in_is_store = st; b_mem_rdata = mrd;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int ren_n, ren_cyc, first_valid;
    logic bad;

    a_reset = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_addr = 64'd0; a_in_wdata = 64'd0;
    a_in_funct3 = 3'd0; a_in_is_load = 1'b0; a_in_is_store = 1'b0; a_mem_rdata = 64'd0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_addr = 64'd0; b_in_wdata = 64'd0;
    b_in_funct3 = 3'd0; b_in_is_load = 1'b0; b_in_is_store = 1'b0; b_mem_rdata = 64'd0;

    vt.push_back(mkv(1, 0, 3'b011, 64'h80000010, 0, 64'h1122334455667788, 64'h1122334455667788, 0, 1, 0, 0));
    vt.push_back(mkv(1, 0, 3'b000, 64'h80000003, 0, 64'h00000000F0000000, 64'hFFFFFFFFFFFFFFF0, 0, 1, 0, 0));
    vt.push_back(mkv(1, 0, 3'b100, 64'h80000003, 0, 64'h00000000F0000000, 64'h00000000000000F0, 0, 1, 0, 0));
    vt.push_back(mkv(0, 1, 3'b001, 64'h80000006, 64'hABCD, 0, 0, 0, 2, 8'hC0, 64'hABCD000000000000));
    vt.push_back(mkv(1, 0, 3'b010, 64'h80000002, 0, 64'hDEAD, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 1, 3'b000, 64'h80000000, 0, 64'hDEAD, 0, 1, 0, 0, 0));
    vt.push_back(mkv(0, 0, 3'b011, 64'h80000008, 0, 64'hDEAD, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 3'b001, 64'h80000004, 0, 64'h0000800100000000, 64'hFFFFFFFFFFFF8001, 0, 1, 0, 0));
    vt.push_back(mkv(1, 0, 3'b101, 64'h80000004, 0, 64'h0000800100000000, 64'h0000000000008001, 0, 1, 0, 0));
    vt.push_back(mkv(1, 0, 3'b010, 64'h80000004, 0, 64'h89ABCDEF00000000, 64'hFFFFFFFF89ABCDEF, 0, 1, 0, 0));
    vt.push_back(mkv(1, 0, 3'b110, 64'h80000004, 0, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF, 0, 1, 0, 0));
    vt.push_back(mkv(0, 1, 3'b011, 64'h80000010, 64'h0123456789ABCDEF, 0, 0, 0, 2, 8'hFF, 64'h0123456789ABCDEF));
    vt.push_back(mkv(0, 1, 3'b000, 64'h80000007, 64'h5A, 0, 0, 0, 2, 8'h80, 64'h5A00000000000000));
    vt.push_back(mkv(0, 1, 3'b010, 64'h80000004, 64'hDEADBEEF, 0, 0, 0, 2, 8'hF0, 64'hDEADBEEF00000000));
    vt.push_back(mkv(0, 1, 3'b100, 64'h80000000, 64'h1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 0, 3'b111, 64'h80000008, 0, 64'hDEAD, 0, 1, 0, 0, 0));
    vt.push_back(mkv(0, 1, 3'b011, 64'h80000004, 64'h1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 0, 3'b001, 64'h80000001, 0, 64'hDEAD, 0, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_out_err", {63'd0, a_out_err}, 64'd0);
    check("rst_out_rdata", a_out_rdata, 64'd0);
    check("rst_strobes", {62'd0, a_mem_ren, a_mem_wen}, 64'd0);
    check("rst_wmask", {56'd0, a_mem_wmask}, 64'd0);
    check("rst_raddr", a_mem_raddr, 64'd0);
    check("rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);
    a_reset = 1'b0;
    b_reset = 1'b0;

    foreach (vt[i]) run_a(vt[i]);
    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // LAT=3 load with out_ready low for 4 RESP cycles and a second request waiting.
    @(negedge clk);
    drive_b(1, 0, 3'b011, 64'h80000018, 64'hCAFEF00D12345678);
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    @(posedge clk);
    ren_n = 0; ren_cyc = 0; first_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (b_mem_ren) begin
        ren_n++; ren_cyc = c;
        check("b_raddr", b_mem_raddr, 64'h80000018);
      end
      if (b_out_valid && first_valid == 0) first_valid = c;
      check("b_in_ready_busy", {63'd0, b_in_ready}, 64'd0);
      if (c >= 5) begin
        check("b_hold_valid", {63'd0, b_out_valid}, 64'd1);
        check("b_hold_rdata", b_out_rdata, 64'hCAFEF00D12345678);
        check("b_hold_err", {63'd0, b_out_err}, 64'd0);
      end else begin
        check("b_pre_rdata", b_out_rdata, 64'd0);
      end
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    check("b_ren_count", 64'(ren_n), 64'd1);
    check("b_ren_cycle", 64'(ren_cyc), 64'd4);
    check("b_first_valid", 64'(first_valid), 64'd5);
    check("b_back_idle", {63'd0, b_in_ready}, 64'd1);
    check("b_valid_dropped", {63'd0, b_out_valid}, 64'd0);
    b_in_valid = 1'b0;

    // LAT=3 error request bypasses the wait: response one cycle after accept.
    @(negedge clk);
    drive_b(1, 0, 3'b010, 64'h80000002, 64'h0);
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    check("b_err_valid", {63'd0, b_out_valid}, 64'd1);
    check("b_err_flag", {63'd0, b_out_err}, 64'd1);
    check("b_err_no_ren", {62'd0, b_mem_ren, b_mem_wen}, 64'd0);
    @(negedge clk);

    // Reset in WAIT discards the load; a request presented under reset is ignored.
    drive_b(1, 0, 3'b011, 64'h80000020, 64'h55);
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b_reset = 1'b1;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    b_in_valid = 1'b0;
    check("b_rst_in_ready", {63'd0, b_in_ready}, 64'd1);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_mem_ren || b_mem_wen || b_out_valid || !b_in_ready) bad = 1'b1;
    end
    check("b_rst_discarded", {63'd0, bad}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: LAT, 0 (range 0..255), number of wait cycles between request acceptance and the memory access cycle.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 in_valid  in  1  upstream request valid.
REQ-005 in_ready  out  1  high only in IDLE.
REQ-006 in_addr  in  64  byte address.
REQ-007 in_wdata  in  64  store data, right-aligned.
REQ-008 in_funct3  in  3  RV64 load/store width/sign code.
REQ-009 in_is_load, in_is_store  in  1 each  operation kind.
REQ-010 out_valid  out  1  response valid.
REQ-011 out_ready  in  1  downstream accepts response.
REQ-012 out_rdata  out  64  aligned, extended load result; 0 for stores, errors and no-ops.
REQ-013 out_err  out  1  request rejected, no memory access made.
REQ-014 mem_raddr, mem_waddr  out  64 each  8-byte-aligned addresses to the memory block.
REQ-015 mem_wdata  out  64  lane-shifted store data.
REQ-016 mem_wmask  out  8  byte-lane enables.
REQ-017 mem_ren, mem_wen  out  1 each  single-cycle access strobes.
REQ-018 mem_rdata  in  64  read data, combinationally valid in the cycle mem_ren is high.

Function
REQ-019 States: IDLE, WAIT, ACCESS, RESP; request fields captured into registers on handshake (in_valid & in_ready).
REQ-020 On accept, a valid memory op goes to WAIT with counter=LAT if LAT>0, else directly to ACCESS; WAIT decrements each cycle and moves to ACCESS when the counter reaches 1.
REQ-021 An accepted error or no-op (neither is_load nor is_store) goes directly to RESP; mem strobes are never asserted for it.
REQ-022 Error conditions: both is_load and is_store; load funct3=111; store funct3>=100; address not aligned to access size (H: addr[0]!=0, W: addr[1:0]!=0, D: addr[2:0]!=0).
REQ-023 In ACCESS, exactly one of mem_ren/mem_wen is high for exactly one cycle; the next state is RESP.
REQ-024 mem_raddr = mem_waddr = captured addr with bits [2:0] forced to 0, driven in all states.
REQ-025 mem_wmask = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) shifted left by addr[2:0]; mem_wdata = in_wdata shifted left by 8*addr[2:0]; mem_wmask=0 outside ACCESS.
REQ-026 Load result = mem_rdata shifted right by 8*addr[2:0], truncated to size, sign-extended for funct3 000/001/010, zero-extended for 100/101/110, full for 011; registered at the end of ACCESS.
REQ-027 Latency accept->out_valid: LAT+2 cycles for memory ops, 1 cycle for errors and no-ops.
REQ-028 RESP holds out_valid, out_rdata and out_err stable until out_ready; on out_ready the next state is IDLE; no new request is accepted in the same cycle.
REQ-029 out_err=1 only in RESP of an error request; out_rdata=0 whenever out_valid=0.

Reset
REQ-030 With reset high at a rising edge: state=IDLE, counter=0, captured registers=0, out_valid=0, out_err=0, out_rdata=0, mem_ren=mem_wen=0, mem_wmask=0, in_ready=1 in the following cycle.
REQ-031 Reset during WAIT, ACCESS or RESP discards the transaction; no strobe is asserted after the reset edge, and no response is produced for it.
REQ-032 reset has priority over handshake; a request presented while reset is high is not accepted.

Verification
REQ-033 LAT=0, LD addr 0x80000010, mem_rdata 0x1122334455667788 -> mem_ren high in cycle 1 only, mem_raddr 0x80000010, out_valid in cycle 2, out_rdata 0x1122334455667788.
REQ-034 LB addr 0x80000003, mem_rdata 0x00000000F0000000 -> out_rdata 0xFFFFFFFFFFFFFFF0; LBU same -> 0x00000000000000F0.
REQ-035 SH addr 0x80000006, in_wdata 0xABCD -> mem_wen one cycle, mem_waddr 0x80000000, mem_wmask 0xC0, mem_wdata 0xABCD000000000000, out_rdata 0.
REQ-036 LW addr 0x80000002 -> no strobes, out_valid one cycle after accept, out_err=1; both kinds asserted -> same.
REQ-037 LAT=3, LD with out_ready held low 4 cycles -> mem_ren in cycle 4 after accept, out_valid from cycle 5, stable until out_ready, in_ready low until return to IDLE.
REQ-038 Reset asserted in WAIT (LAT=3) -> no mem_ren, out_valid=0, in_ready=1 the cycle after reset deasserts.
